// File: rtl/mem_bus_arbiter_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//
// Shared definitions for the two-requester memory bus arbiter:
//   state_t   - arbiter FSM states (idle, I-side line burst, D-side single access)
//   grant_t   - identifies which requester was served most recently
//   idx_width - width of the word-within-line index for a given line length
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_I_BURST = 2'd1,
      ST_D_ACC   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   // Index width for a line of line_words words. Never returns 0, so a
   // degenerate one-word line still yields a legal vector.
   function automatic int idx_width(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arb_rr2
//
// Two-way round-robin priority picker. A lone requester always wins; when
// both request, the side that was NOT granted last time wins.
//
// Ports:
//   req_i      in   I-side request
//   req_d      in   D-side request
//   last_grant in   side served by the most recent completed transaction
//   grant_i    out  I-side wins this cycle
//   grant_d    out  D-side wins this cycle (one-hot with grant_i)
// -----------------------------------------------------------------------------
module mem_arb_rr2
   import mem_bus_arbiter_pkg::*;
(
   input  logic   req_i,
   input  logic   req_d,
   input  grant_t last_grant,
   output logic   grant_i,
   output logic   grant_d
);

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (req_i && req_d) begin
         if (last_grant == GNT_I) begin
            grant_d = 1'b1;
         end else begin
            grant_i = 1'b1;
         end
      end else begin
         grant_i = req_i;
         grant_d = req_d;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one word-wide memory port between the I-cache refill engine (burst
// of LINE_WORDS words per line) and the data memory stage (single word).
// Arbitration happens only in IDLE, is round-robin on ties, and is never
// preemptive: a started burst or access always runs to completion.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_req, i_addr   I-side refill request and miss address (line-aligned here)
//   i_wdata_valid   refill word present on i_rdata / i_widx this cycle
//   i_rdata, i_widx refill word and its index within the line
//   i_done          pulse together with the last refill word
//   d_req, d_wen,   D-side request, write enable, byte address, write data;
//   d_addr, d_wdata held stable until d_ack
//   d_rdata, d_ack  D-side read data (0 for writes) and completion pulse
//   mem_cs, mem_we, external access strobe, write enable, byte address,
//   mem_addr,       write data
//   mem_dout
//   mem_din,mem_ack external read data and completion
//
// All outputs are registered. A grant takes one cycle (mem_cs rises in the
// first cycle of the granted state), and every completion returns to IDLE,
// so mem_cs is low for at least one cycle between transactions.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter  int LINE_WORDS = 4,
   parameter  int ADDR_W     = 32,
   parameter  int DATA_W     = 32,
   localparam int IDX_W      = idx_width(LINE_WORDS)
)(
   input  logic              clk,
   input  logic              rst,

   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_wdata_valid,
   output logic [DATA_W-1:0] i_rdata,
   output logic [IDX_W-1:0]  i_widx,
   output logic              i_done,

   input  logic              d_req,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,

   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dout,
   input  logic [DATA_W-1:0] mem_din,
   input  logic              mem_ack
);

   // Byte offset bits covered by one line (word index + 2 byte-select bits).
   localparam int                OFF_W     = IDX_W + 2;
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
   localparam logic [IDX_W-1:0]  CNT_LAST  = IDX_W'(LINE_WORDS - 1);

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_t              state_reg;
   grant_t              last_grant_reg;
   logic [IDX_W-1:0]    cnt_reg;
   logic [ADDR_W-1:0]   base_reg;

   logic                mem_cs_reg;
   logic                mem_we_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic [DATA_W-1:0]   mem_dout_reg;
   logic                i_wdata_valid_reg;
   logic [DATA_W-1:0]   i_rdata_reg;
   logic [IDX_W-1:0]    i_widx_reg;
   logic                i_done_reg;
   logic [DATA_W-1:0]   d_rdata_reg;
   logic                d_ack_reg;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic grant_i;
   logic grant_d;

   mem_arb_rr2 u_rr2 (
      .req_i      (i_req),
      .req_d      (d_req),
      .last_grant (last_grant_reg),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

   // ---------------------------------------------------------------------
   // Burst address generation
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]  cnt_next;
   logic [ADDR_W-1:0] line_base_next;
   logic [ADDR_W-1:0] word_off_next;
   logic [ADDR_W-1:0] burst_addr_next;

   always_comb begin
      cnt_next       = cnt_reg + IDX_W'(1);
      line_base_next = i_addr & LINE_MASK;
      word_off_next  = '0;
      word_off_next[OFF_W-1:2] = cnt_next;
      // base is line aligned, so adding the offset never carries out of
      // the line; the wrapped index on the final word points back at base.
      burst_addr_next = base_reg + word_off_next;
   end

   // ---------------------------------------------------------------------
   // FSM, counter and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         last_grant_reg    <= GNT_I;
         cnt_reg           <= '0;
         base_reg          <= '0;
         mem_cs_reg        <= 1'b0;
         mem_we_reg        <= 1'b0;
         mem_addr_reg      <= '0;
         mem_dout_reg      <= '0;
         i_wdata_valid_reg <= 1'b0;
         i_rdata_reg       <= '0;
         i_widx_reg        <= '0;
         i_done_reg        <= 1'b0;
         d_rdata_reg       <= '0;
         d_ack_reg         <= 1'b0;
      end else begin
         // Completion strobes are single-cycle pulses.
         i_wdata_valid_reg <= 1'b0;
         i_done_reg        <= 1'b0;
         d_ack_reg         <= 1'b0;

         unique case (state_reg)
            ST_IDLE: begin
               // mem_ack here belongs to no access and is ignored.
               if (grant_d) begin
                  state_reg    <= ST_D_ACC;
                  mem_cs_reg   <= 1'b1;
                  mem_we_reg   <= d_wen;
                  mem_addr_reg <= d_addr;
                  mem_dout_reg <= d_wdata;
               end else if (grant_i) begin
                  state_reg    <= ST_I_BURST;
                  cnt_reg      <= '0;
                  base_reg     <= line_base_next;
                  mem_cs_reg   <= 1'b1;
                  mem_we_reg   <= 1'b0;
                  mem_addr_reg <= line_base_next;
                  mem_dout_reg <= '0;
               end
            end

            ST_D_ACC: begin
               // The requester holds d_wen/d_addr/d_wdata stable, so the
               // values captured at grant remain the ones being driven.
               if (mem_ack) begin
                  d_ack_reg      <= 1'b1;
                  d_rdata_reg    <= mem_we_reg ? '0 : mem_din;
                  last_grant_reg <= GNT_D;
                  mem_cs_reg     <= 1'b0;
                  mem_we_reg     <= 1'b0;
                  state_reg      <= ST_IDLE;
               end
            end

            ST_I_BURST: begin
               if (mem_ack) begin
                  i_wdata_valid_reg <= 1'b1;
                  i_rdata_reg       <= mem_din;
                  i_widx_reg        <= cnt_reg;
                  cnt_reg           <= cnt_next;
                  mem_addr_reg      <= burst_addr_next;
                  if (cnt_reg == CNT_LAST) begin
                     // cnt_next has wrapped to zero, ready for the next line.
                     i_done_reg     <= 1'b1;
                     last_grant_reg <= GNT_I;
                     mem_cs_reg     <= 1'b0;
                     state_reg      <= ST_IDLE;
                  end
               end
            end

            default: begin
               state_reg  <= ST_IDLE;
               mem_cs_reg <= 1'b0;
               mem_we_reg <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output wiring
   // ---------------------------------------------------------------------
   assign mem_cs        = mem_cs_reg;
   assign mem_we        = mem_we_reg;
   assign mem_addr      = mem_addr_reg;
   assign mem_dout      = mem_dout_reg;
   assign i_wdata_valid = i_wdata_valid_reg;
   assign i_rdata       = i_rdata_reg;
   assign i_widx        = i_widx_reg;
   assign i_done        = i_done_reg;
   assign d_rdata       = d_rdata_reg;
   assign d_ack         = d_ack_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Scoreboard bench: stimulus tasks push the expected outcome of every
// transaction into queues; a monitor pops and compares whenever the DUT
// presents a refill word or a D-side acknowledge. A behavioural memory
// responds with programmable latency and records each completed access.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int LW = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = $clog2(LW);
   localparam int TMO = 500;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_wdata_valid;
   logic [DW-1:0] i_rdata;
   logic [IW-1:0] i_widx;
   logic          i_done;
   logic          d_req;
   logic          d_wen;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic [DW-1:0] mem_din;
   logic          mem_ack;

   mem_bus_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_wdata_valid(i_wdata_valid),
      .i_rdata(i_rdata), .i_widx(i_widx), .i_done(i_done),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Contents of any never-written location.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   // ---------------------------------------------------------------------
   // Behavioural memory: ack arrives lat_cur cycles after the first cycle
   // of each access (never in the cycle mem_cs rises).
   // ---------------------------------------------------------------------
   logic [31:0] mem_arr [logic [31:0]];
   int          lat_fixed = 1;
   int          lat_cur   = 1;
   int          wait_cnt  = 0;
   logic [31:0] last_addr;
   logic [31:0] last_dout;
   logic        last_we;

   task automatic set_lat(input int l);
      lat_fixed = l;
      lat_cur   = (l > 0) ? l : $urandom_range(1, 5);
   endtask

   initial begin
      mem_ack = 1'b0;
      mem_din = '0;
      forever begin
         @(negedge clk);
         if (rst || !mem_cs) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end else if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 1;
         end else begin
            wait_cnt++;
            if (wait_cnt > lat_cur) begin
               mem_ack   = 1'b1;
               last_addr = mem_addr;
               last_we   = mem_we;
               last_dout = mem_dout;
               if (mem_we) begin
                  mem_arr[mem_addr] = mem_dout;
                  mem_din = $urandom;
               end else begin
                  mem_din = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
               end
               lat_cur = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 5);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          widx;
   } iexp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } dexp_t;

   iexp_t       iq[$];
   dexp_t       dq[$];
   int          done_log[$];       // 0 = I line completed, 1 = D access completed
   logic [31:0] d_model [logic [31:0]];
   int          cs_len = 0;
   int          last_cs_len = 0;

   task automatic push_i_exp(input logic [31:0] addr);
      iexp_t       e;
      logic [31:0] base;
      base = addr - (addr % (LW * 4));
      for (int k = 0; k < LW; k++) begin
         e.addr = base + 32'(4 * k);
         e.data = init_word(e.addr);
         e.widx = k;
         iq.push_back(e);
      end
   endtask

   task automatic push_d_exp(input logic we, input logic [31:0] addr, input logic [31:0] data);
      dexp_t e;
      e.we    = we;
      e.addr  = addr;
      e.wdata = data;
      if (we) begin
         d_model[addr] = data;
         e.rdata = '0;
      end else begin
         e.rdata = d_model.exists(addr) ? d_model[addr] : init_word(addr);
      end
      dq.push_back(e);
   endtask

   initial begin : monitor
      iexp_t ie;
      dexp_t de;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_cs) begin
               cs_len++;
            end else if (cs_len != 0) begin
               last_cs_len = cs_len;
               cs_len = 0;
            end
            if (i_wdata_valid) begin
               chk("i_word_expected", i_wdata_valid, iq.size() > 0);
               if (iq.size() > 0) begin
                  ie = iq.pop_front();
                  chk("i_widx", i_widx, ie.widx);
                  chk("i_rdata", i_rdata, ie.data);
                  chk("i_mem_addr", last_addr, ie.addr);
                  chk("i_mem_we", last_we, 1'b0);
                  chk("i_done_on_last", i_done, ie.widx == LW - 1);
               end
            end
            if (i_done) begin
               chk("i_done_with_word", i_wdata_valid, 1'b1);
               done_log.push_back(0);
            end
            if (d_ack) begin
               chk("d_ack_expected", d_ack, dq.size() > 0);
               if (dq.size() > 0) begin
                  de = dq.pop_front();
                  chk("d_rdata", d_rdata, de.rdata);
                  chk("d_mem_addr", last_addr, de.addr);
                  chk("d_mem_we", last_we, de.we);
                  if (de.we) chk("d_mem_dout", last_dout, de.wdata);
               end
               done_log.push_back(1);
            end
            if (d_ack || i_done) chk("cs_gap_after_done", mem_cs, 1'b0);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus tasks
   // ---------------------------------------------------------------------
   task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] data);
      logic got;
      int   waited;
      int   opp;
      push_d_exp(we, addr, data);
      d_wen = we; d_addr = addr; d_wdata = data; d_req = 1'b1;
      got = 1'b0; waited = 0; opp = 0;
      while (!got && waited < TMO) begin
         @(negedge clk);
         waited++;
         if (d_ack) got = 1'b1;
         else if (i_done) opp++;
      end
      chk("d_ack_timeout", got, 1'b1);
      chk("d_no_starve", opp <= 1, 1'b1);
      d_req = 1'b0;
   endtask

   task automatic do_i(input logic [31:0] addr);
      logic got;
      int   waited;
      int   opp;
      push_i_exp(addr);
      i_addr = addr; i_req = 1'b1;
      got = 1'b0; waited = 0; opp = 0;
      while (!got && waited < TMO) begin
         @(negedge clk);
         waited++;
         if (i_done) got = 1'b1;
         else if (d_ack) opp++;
      end
      chk("i_done_timeout", got, 1'b1);
      chk("i_no_starve", opp <= 1, 1'b1);
      i_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem_cs"}, mem_cs, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_dout"}, mem_dout, 0);
      chk({tag, "_i_wdata_valid"}, i_wdata_valid, 0);
      chk({tag, "_i_rdata"}, i_rdata, 0);
      chk({tag, "_i_widx"}, i_widx, 0);
      chk({tag, "_i_done"}, i_done, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_d_ack"}, d_ack, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   initial begin : main
      logic got;
      int   waited;
      rst = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;

      // Asynchronous reset: outputs must clear before any clock edge.
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // D read alone, ack in the second cs cycle.
      set_lat(1);
      mem_arr[32'h100] = 32'hDEAD_BEEF;
      d_model[32'h100] = 32'hDEAD_BEEF;
      do_d(1'b0, 32'h100, 32'h0);
      @(negedge clk);
      chk("d_read_cs_cycles", last_cs_len, 2);

      // I refill from an unaligned miss address.
      do_i(32'h2034);
      @(negedge clk);
      chk("i_refill_cs_cycles", last_cs_len, 2 * LW);

      // Simultaneous requests after reset: D wins the first tie.
      apply_reset();
      @(negedge clk);
      done_log.delete();
      fork
         do_d(1'b1, 32'h40, 32'h1234_5678);
         do_i(32'h3000);
      join
      @(negedge clk);
      chk("tie1_count", done_log.size(), 2);
      if (done_log.size() >= 2) begin
         chk("tie1_first_is_d", done_log[0], 1);
         chk("tie1_second_is_i", done_log[1], 0);
      end
      // Lone D read-back makes D the last grant; the next tie goes to I.
      do_d(1'b0, 32'h40, 32'h0);
      @(negedge clk);
      done_log.delete();
      fork
         do_i(32'h3040);
         do_d(1'b0, 32'h44, 32'h0);
      join
      @(negedge clk);
      chk("tie2_count", done_log.size(), 2);
      if (done_log.size() >= 2) begin
         chk("tie2_first_is_i", done_log[0], 0);
         chk("tie2_second_is_d", done_log[1], 1);
      end

      // D request raised in the second cycle of a burst waits for i_done.
      push_i_exp(32'h5000);
      i_addr = 32'h5000; i_req = 1'b1;
      repeat (2) @(negedge clk);
      push_d_exp(1'b1, 32'h8000_0010, 32'hCAFE_F00D);
      d_wen = 1'b1; d_addr = 32'h8000_0010; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
      got = 1'b0; waited = 0;
      while (!got && waited < TMO) begin
         @(negedge clk);
         waited++;
         if (i_done) begin
            got = 1'b1;
         end else begin
            chk("mid_burst_we", mem_we, 1'b0);
            chk("mid_burst_addr", mem_addr & 32'hFFFF_FFF0, 32'h5000);
         end
      end
      chk("mid_burst_i_done_timeout", got, 1'b1);
      i_req = 1'b0;
      chk("mid_burst_idle_cycle", mem_cs, 1'b0);
      @(negedge clk);
      chk("mid_burst_d_cs", mem_cs, 1'b1);
      chk("mid_burst_d_addr", mem_addr, 32'h8000_0010);
      chk("mid_burst_d_we", mem_we, 1'b1);
      got = 1'b0; waited = 0;
      while (!got && waited < TMO) begin
         if (d_ack) got = 1'b1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      chk("mid_burst_d_ack_timeout", got, 1'b1);
      d_req = 1'b0;
      @(negedge clk);

      // Asynchronous reset during word 2 of a burst.
      set_lat(2);
      push_i_exp(32'h2030);
      i_addr = 32'h2030; i_req = 1'b1;
      got = 1'b0; waited = 0;
      while (!got && waited < TMO) begin
         @(negedge clk);
         waited++;
         if (i_wdata_valid && i_widx == 0) got = 1'b1;
      end
      chk("rst_mid_first_word_timeout", got, 1'b1);
      #2 rst = 1'b1;
      #1 check_all_zero("rst_mid");
      i_req = 1'b0;
      repeat (2) @(negedge clk);
      iq.delete();
      rst = 1'b0;
      do_i(32'h2030);

      // Random mixed traffic with random latency.
      set_lat(0);
      fork
         begin
            for (int n = 0; n < 250; n++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               do_i(32'h1000_0000 | ($urandom & 32'h0FFF_FFFF));
            end
         end
         begin
            for (int n = 0; n < 750; n++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               do_d(1'($urandom_range(0, 1)),
                    32'h8000_0000 | (32'($urandom_range(0, 31)) << 2),
                    $urandom);
            end
         end
      join

      repeat (3) @(negedge clk);
      chk("i_queue_drained", iq.size(), 0);
      chk("d_queue_drained", dq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
